// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: shared FSM state type and slice width for the sequential CLA adder.
package cla_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} cla_seq_state_t;
    localparam int SLICE_W = 4;
endpackage

// File: rtl/cla_seq_adder_cla4b.sv
// cla_4b: 4-bit carry-lookahead slice with group propagate/generate outputs.
module cla_4b (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c,
    output logic [3:0] o_s,
    output logic       o_c,
    output logic       o_p_total,
    output logic       o_g_total
);
    logic [3:0] w_p, w_g;
    logic [4:0] w_c;
    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;
    assign w_c[0] = i_c;
    assign w_c[1] = w_g[0] | (w_p[0] & i_c);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_c);
    assign o_g_total = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                     | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign o_p_total = &w_p;
    assign w_c[4] = o_g_total | (o_p_total & i_c);
    assign o_s = w_p ^ w_c[3:0];
    assign o_c = w_c[4];
endmodule

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: W-bit add/sub reusing one 4-bit CLA slice, one chunk per cycle, LSB first.
// Define CLA_SEQ_OVF_EN to add the signed-overflow output out_ovf.
module cla_seq_adder
    import cla_seq_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
`ifdef CLA_SEQ_OVF_EN
    output logic         out_ovf,
`endif
    output logic         out_c
);
    localparam int NCHUNK = W / SLICE_W;
    localparam int CW = $clog2(NCHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    cla_seq_state_t r_state, w_next;
    logic [W-1:0] r_a, r_b, r_sum;
    logic [CW-1:0] r_cnt;
    logic r_carry, r_fin, r_c;
    logic w_accept, w_step, w_last, w_co;
    logic [SLICE_W-1:0] w_ca, w_cb, w_s;
`ifdef CLA_SEQ_OVF_EN
    logic r_ovf;
    assign out_ovf = r_ovf;
`endif

    assign w_ca = r_a[r_cnt * SLICE_W +: SLICE_W];
    assign w_cb = r_b[r_cnt * SLICE_W +: SLICE_W];
    assign w_last = r_cnt == LAST;
    assign out_sum = r_sum;
    assign out_c = r_c;

    cla_4b u_slice (
        .i_a       (w_ca),
        .i_b       (w_cb),
        .i_c       (r_carry),
        .o_s       (w_s),
        .o_c       (w_co),
        .o_p_total (),
        .o_g_total ()
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end

    // r_fin marks that the top chunk is done; DONE is entered one edge later
    always_comb begin
        w_next = r_state;
        in_ready = 1'b0;
        out_valid = 1'b0;
        w_accept = 1'b0;
        w_step = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                w_next = in_valid ? RUN : IDLE;
            end
            RUN: begin
                w_step = !r_fin;
                w_next = r_fin ? DONE : RUN;
            end
            DONE: begin
                out_valid = 1'b1;
                w_next = out_ready ? IDLE : DONE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
            r_sum <= '0;
            r_cnt <= '0;
            r_carry <= 1'b0;
            r_fin <= 1'b0;
            r_c <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
            r_ovf <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a <= in_a;
            r_b <= in_b ^ {W{in_sub}};
            r_carry <= in_sub;
            r_cnt <= '0;
            r_fin <= 1'b0;
        end else if (w_step) begin
            r_sum[r_cnt * SLICE_W +: SLICE_W] <= w_s;
            r_carry <= w_co;
            r_cnt <= r_cnt + CW'(1);
            r_fin <= w_last;
            if (w_last) r_c <= w_co;
`ifdef CLA_SEQ_OVF_EN
            if (w_last) r_ovf <= (r_a[W-1] == r_b[W-1]) && (w_s[SLICE_W-1] != r_a[W-1]);
`endif
        end
    end
endmodule

// File: tb/tb_cla_seq_adder.sv
// tb_cla_seq_adder: directed scoreboard bench for cla_seq_adder at W=16.
// Overflow checks are active when CLA_SEQ_OVF_EN is defined.
module tb_cla_seq_adder;
    typedef struct packed {
        logic [15:0] sum;
        logic        c;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_sub = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, out_c, ovf_obs;
    logic [15:0] in_a = '0, in_b = '0, out_sum;
    exp_t q[$];
    exp_t e;
    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    cla_seq_adder #(.W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
`ifdef CLA_SEQ_OVF_EN
        .out_ovf   (ovf_obs),
`endif
        .out_c     (out_c)
    );
`ifndef CLA_SEQ_OVF_EN
    assign ovf_obs = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic sub);
        logic [15:0] bb;
        logic [16:0] r;
        exp_t x;
        bb = sub ? ~b : b;
        r = {1'b0, a} + {1'b0, bb} + {16'b0, sub};
        x.sum = r[15:0];
        x.c = r[16];
        x.ovf = (a[15] == bb[15]) && (r[15] != a[15]);
        return x;
    endfunction

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sub);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
        in_a = a;
        in_b = b;
        in_sub = sub;
        in_valid = 1'b1;
        q.push_back(model(a, b, sub));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, output exp_t x);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 32'd5);
        x = q.pop_front();
        chk({tag, "_sum"}, {16'b0, out_sum}, {16'b0, x.sum});
        chk({tag, "_c"}, {31'b0, out_c}, {31'b0, x.c});
`ifdef CLA_SEQ_OVF_EN
        chk({tag, "_ovf"}, {31'b0, ovf_obs}, {31'b0, x.ovf});
`endif
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_ready_back"}, {31'b0, in_ready}, 32'd1);
    endtask

    task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic sub);
        exp_t x;
        issue(a, b, sub);
        wait_done(tag, x);
        release_out(tag);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_sum", {16'b0, out_sum}, 32'd0);
        chk("rst_out_c", {31'b0, out_c}, 32'd0);
        chk("rst_out_ovf", {31'b0, ovf_obs}, 32'd0);

        op("add_1234", 16'h1234, 16'h4321, 1'b0);
        op("add_ffff", 16'hFFFF, 16'h0001, 1'b0);
        op("sub_5_7", 16'h0005, 16'h0007, 1'b1);
        op("add_7fff", 16'h7FFF, 16'h0001, 1'b0);
        op("sub_8000", 16'h8000, 16'h0001, 1'b1);
        op("sub_eq", 16'hA5A5, 16'hA5A5, 1'b1);
        op("add_mix", 16'h8001, 16'h8001, 1'b0);

        // back-pressure: result must hold and new requests must be ignored
        issue(16'hBEEF, 16'h0102, 1'b0);
        wait_done("hold", e);
        in_valid = 1'b1;
        in_a = 16'h1111;
        in_b = 16'h2222;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_sum", {16'b0, out_sum}, {16'b0, e.sum});
            chk("hold_c", {31'b0, out_c}, {31'b0, e.c});
            chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        release_out("hold");
        tick();
        chk("hold_no_new_op", {31'b0, in_ready}, 32'd1);

        // abort mid-RUN after two chunks
        issue(16'h1234, 16'h0F0F, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(q.pop_front());
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
        chk("abort_out_sum", {16'b0, out_sum}, 32'd0);
        chk("abort_out_c", {31'b0, out_c}, 32'd0);
        op("post_abort", 16'h0001, 16'h0001, 1'b0);

        for (int i = 0; i < 4; i++)
            op("rand", 16'($urandom), 16'($urandom), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
